// File: rtl/apb_mailbox_fifo.sv
// APB3 mailbox: host pushes 32-bit words over APB, a cluster consumer drains them
// over valid/ready. Status, sticky error flags and a level-threshold interrupt.
module apb_mailbox_fifo #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int DEPTH          = 16,
  parameter int LOG_DEPTH      = $clog2(DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [31:0]               data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      irq_o
);

  localparam int LVL_W = LOG_DEPTH + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } apb_state_e;

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_STATUS = 3'd1,
    REG_CTRL   = 3'd2,
    REG_THRESH = 3'd3
  } reg_addr_e;

  apb_state_e           state, state_next;
  logic [31:0]          mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level;
  logic                 irq_en;
  logic [7:0]           thresh;
  logic                 overflow, underflow;
  logic                 irq_q;

  logic        empty, full;
  logic        commit, do_push, ovf_set, unf_set, pop;
  logic        ctrl_wr, flush, clr_sticky, thresh_wr;
  logic [2:0]  reg_addr;
  logic [31:0] rd_word, status_word;
  logic        rd_err;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  assign reg_addr = PADDR[4:2];
  assign empty    = (level == '0);
  assign full     = (level == FULL_LEVEL);
  assign valid_o  = !empty;
  assign data_o   = mem[rd_ptr];
  assign irq_o    = irq_q;

  assign status_word = {20'b0, underflow, overflow, full, empty, 8'(level)};

  // Side effects land on the edge that ends the response cycle; a dropped PSEL aborts.
  assign commit     = (state == ST_RESP) && PSEL;
  assign do_push    = commit && PWRITE && (reg_addr == REG_DATA) && !full;
  assign ovf_set    = commit && PWRITE && (reg_addr == REG_DATA) && full;
  assign ctrl_wr    = commit && PWRITE && (reg_addr == REG_CTRL);
  assign thresh_wr  = commit && PWRITE && (reg_addr == REG_THRESH);
  assign flush      = ctrl_wr && PWDATA[1];
  assign clr_sticky = ctrl_wr && PWDATA[2];
  assign pop        = valid_o && ready_i;
  assign unf_set    = ready_i && !valid_o;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (PSEL && PENABLE) state_next = ST_WAIT;
      ST_WAIT: state_next = PSEL ? ST_RESP : ST_IDLE;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (reg_addr)
      REG_DATA:   rd_err  = PWRITE ? full : 1'b1;
      REG_STATUS: rd_word = PWRITE ? '0 : status_word;
      REG_CTRL:   rd_word = PWRITE ? '0 : {31'b0, irq_en};
      REG_THRESH: rd_word = PWRITE ? '0 : {24'b0, thresh};
      default:    rd_err  = 1'b1;
    endcase
  end

  assign PREADY  = (state == ST_RESP);
  assign PRDATA  = PREADY ? rd_word : '0;
  assign PSLVERR = PREADY && rd_err;

  // NOTE: the storage array has no reset; emptiness is tracked by the level
  // counter, so stale words are never observable and the array can map to RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= PWDATA;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
      if (pop)     rd_ptr <= rd_ptr + LOG_DEPTH'(1);
      case ({do_push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_en <= 1'b0;
      thresh <= '0;
    end else begin
      if (ctrl_wr)   irq_en <= PWDATA[0];
      if (thresh_wr) thresh <= PWDATA[7:0];
    end
  end

  // A set event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)         overflow  <= 1'b1;
      else if (clr_sticky) overflow  <= 1'b0;
      if (unf_set)         underflow <= 1'b1;
      else if (clr_sticky) underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= irq_en && (thresh != '0) && (8'(level) >= thresh);
  end

endmodule

// File: doc/apb_mailbox_fifo.md
Name: apb_mailbox_fifo

Overview:
- APB3 completer on one peripheral slot of the SoC APB bus, behind the AXI-to-APB bridge.
- Host software pushes 32-bit words through APB register writes.
- A cluster-side consumer drains the words over a valid/ready stream.
- Provides fill status, sticky error flags and a level-threshold interrupt.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR; only PADDR[4:2] is decoded.
- DEPTH, 16, number of FIFO entries; power of two, 2..128.
- LOG_DEPTH, $clog2(DEPTH), derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- PADDR  in  APB_ADDR_WIDTH  APB address
- PWDATA  in  32  APB write data
- PWRITE  in  1  APB direction, 1 = write
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PRDATA  out  32  APB read data
- PREADY  out  1  APB ready
- PSLVERR  out  1  APB error
- data_o  out  32  stream data, head of FIFO
- valid_o  out  1  FIFO not empty
- ready_i  in  1  consumer accepts data_o
- irq_o  out  1  level interrupt, registered

Behaviour:
- Reset: FIFO empty, pointers 0, CTRL=0, THRESH=0, sticky flags 0, FSM IDLE.
- Outputs after reset: PREADY=0, PSLVERR=0, PRDATA=0, valid_o=0, irq_o=0. data_o is don't-care while valid_o=0.
- Reset asserted mid-transfer: FIFO contents are discarded; the in-flight APB transfer is abandoned with no response.
- APB FSM, exactly one wait state:
  - IDLE: on PSEL&PENABLE go to WAIT; PREADY=0.
  - WAIT: PREADY=0; go to RESP.
  - RESP: PREADY=1, PRDATA and PSLVERR valid; return to IDLE.
  - Transfer side effects commit at the rising edge that ends the RESP cycle.
  - If PSEL drops before RESP (protocol violation), return to IDLE with no side effect.
- Register map (PADDR[4:2]):
  - 0x00 DATA: write pushes PWDATA. Read returns 0 with PSLVERR=1.
  - 0x04 STATUS (RO): [7:0] level (zero-extended); [8] empty; [9] full; [10] overflow sticky; [11] underflow sticky; rest 0. Write is ignored, PSLVERR=0.
  - 0x08 CTRL: [0] irq_en (RW). [1] flush (write 1 empties the FIFO; self-clearing, reads 0). [2] write 1 clears both sticky flags; reads 0.
  - 0x0C THRESH: [7:0] RW, irq threshold; upper bits read 0.
  - 0x10-0x1C: reads 0, writes ignored, PSLVERR=1.
- Push to a full FIFO: word dropped, PSLVERR=1, overflow sticky set.
  - Full is sampled before any same-cycle stream pop, so a push coinciding with a pop from a full FIFO is still rejected.
- Stream pop: valid_o = !empty; data_o = mem[rd_ptr]. A transfer occurs when valid_o&ready_i; rd_ptr increments at that edge.
- Simultaneous push and pop on a non-full, non-empty FIFO: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Level is held in LOG_DEPTH+1 bits, range 0..DEPTH.
- Flush commit coinciding with a stream pop: the popped word counts as consumed; FIFO is empty afterwards.
- Underflow sticky: set when ready_i=1 and valid_o=0 at a clock edge.
- A sticky clear committing in the same cycle as a new set event: the set wins.
- irq_o (registered) = irq_en & (THRESH!=0) & (level >= THRESH). Updates the cycle after level or configuration changes.

Test Plan:
- Reset, then read STATUS -> PRDATA=0x100, PSLVERR=0. Every APB transfer shows exactly 1 wait-state cycle with PREADY=0 before PREADY=1.
- Push 0xA5A5_0001..0xA5A5_0003 with ready_i=0 -> STATUS=0x003. Then raise ready_i -> data_o sequence 01,02,03 on consecutive cycles; valid_o then drops to 0.
- Fill DEPTH=16 words, then push 0xDEAD_BEEF -> PSLVERR=1, STATUS=0x610. Next pop returns the first word, not 0xDEADBEEF.
- With FIFO full, push while ready_i=1 in the commit cycle -> push rejected, PSLVERR=1, level becomes 15.
- THRESH=4, CTRL=1, push 4 words -> irq_o rises 1 cycle after the 4th commit. One pop -> irq_o falls. Write CTRL=0x3 -> level 0, irq_o stays 0.
- Read DATA -> PSLVERR=1, PRDATA=0. Raise ready_i on an empty FIFO -> STATUS[11]=1. Write CTRL[2]=1 -> flag cleared. Access 0x14 -> PSLVERR=1.
